vga_sync_decoder: RTL
=====================

Name: vga_sync_decoder

Overview:
- Receive side of the VGA timing interface. Takes the Hsynq/Vsynq pair driven by the display timing generator (or an external source) and recovers pixel coordinates, active-video qualification and a lock indication.
- Used for loopback self-check of the game's timing path and for capturing an external VGA stream into the render pipeline.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_POL, 0, asserted level of both syncs (0 = active-low)
- LOCK_FRAMES, 2, consecutive conforming frames required for lock (range 1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel-rate enable (one pulse per pixel, e.g. every 2nd clk)
- Hsynq  in  1  horizontal sync
- Vsynq  in  1  vertical sync
- x  out  16  recovered column, 0..H_ACTIVE-1
- y  out  16  recovered row, 0..V_ACTIVE-1
- active  out  1  x/y are valid visible coordinates
- frame_start  out  1  one-clk pulse on each Vsynq assertion edge
- locked  out  1  timing matches parameters
- sync_err  out  1  one-clk pulse on any line/frame length mismatch

Behaviour:
- Reset: all outputs 0; h_cnt = v_cnt = 0; good_cnt = 0; FSM = SEARCH; sync history registers are loaded with the deasserted level.
- All state advances only on clk cycles where pix_en = 1. When pix_en = 0, everything holds, and frame_start and sync_err are 0.
- Edge detection: the assertion edge is defined as the current input at the asserted level while the registered previous sample is deasserted.
- h_cnt (16 bit): set to 0 on an Hsynq edge; otherwise increments, saturating at 16'hFFFF.
- v_cnt (16 bit): set to 0 on a Vsynq edge; otherwise increments on an Hsynq edge, saturating. If both edges occur on the same sample, v_cnt = 0 and Vsynq wins.
- Line length measured at an Hsynq edge is h_cnt+1; it must equal H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800).
- Frame length measured at a Vsynq edge is v_cnt+1; it must equal V_TOTAL (525). The first partial line or frame after reset or after leaving SEARCH is not checked.
- Active region: active = locked AND h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] AND v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
  - When active: x = h_cnt-(H_SYNC+H_BP), y = v_cnt-(V_SYNC+V_BP).
  - When not active: x = y = 0.
- Outputs are registered, with a latency of 1 clk after the pix_en sample.
- FSM:
  - SEARCH: on a Vsynq edge, go to CHECK with good_cnt = 0.
  - CHECK: any line mismatch goes to SEARCH and pulses sync_err. A conforming frame at a Vsynq edge does good_cnt++. When good_cnt reaches LOCK_FRAMES, go to LOCKED and set locked = 1 on the same registered update.
  - LOCKED: any line or frame mismatch, or h_cnt saturating, goes to SEARCH. sync_err pulses and locked = 0 on the same update.
- Reset asserted mid-frame: outputs return to reset values on the next clk, regardless of pix_en.

Optional Feature:
- Macro VGA_DEC_MEASURE_EN.
- Defined: adds outputs h_total_meas[15:0] and v_total_meas[15:0], registered with the last measured line and frame lengths (reset 0, updated at every edge, including in SEARCH). Also adds err_count[7:0], which counts sync_err pulses, saturates at 255, and is cleared by reset.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package vga_dec_pkg holds:
  - the default timing constants, plus derived H_TOTAL/V_TOTAL and the active start/end values;
  - typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} dec_state_t.
- Sub-module vga_sync_edge (sample register plus polarity-aware assertion-edge detect, gated by pix_en) is instantiated once for Hsynq and once for Vsynq.

Test Plan:
- Reference 640x480 stream, pix_en every 2nd clk, 3 frames -> locked=1 at the Vsynq edge ending the 2nd full frame; frame_start pulses once per 525 lines.
- Locked stream -> first active sample x=0,y=0 at h_cnt=144,v_cnt=35; last active x=639,y=479; active never high outside these bounds.
- Locked, one line shortened to 799 pixels -> one-clk sync_err at that Hsynq edge, locked=0 on the same clk, relock after 2 good frames.
- Hsynq and Vsynq edges in the same pix_en sample -> v_cnt=0, no line-count increment.
- Reset asserted mid-active line -> next clk: x=y=0, active=locked=0, FSM SEARCH; pix_en held low for 10 clks while locked -> all outputs frozen.
- Macro defined, 801-pixel line -> h_total_meas=801, err_count increments by 1.

Source files
------------

// File: rtl/vga_dec_pkg.sv
// Shared timing defaults, derived line/frame geometry and FSM state type
// for the VGA sync decoder.
package vga_dec_pkg;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam bit DEF_SYNC_POL    = 1'b0;
    localparam int DEF_LOCK_FRAMES = 2;

    localparam int DEF_H_TOTAL     = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_V_TOTAL     = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_H_ACT_START = DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_H_ACT_END   = DEF_H_ACT_START + DEF_H_ACTIVE - 1;
    localparam int DEF_V_ACT_START = DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_V_ACT_END   = DEF_V_ACT_START + DEF_V_ACTIVE - 1;

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} dec_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registered sync sample plus polarity-aware assertion-edge detect,
// advanced only on pixel-enable cycles.
module vga_sync_edge #(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pix_en,
    input  logic sync,
    output logic assert_edge
);

    logic prev;

    // NOTE: history resets to the deasserted level so a sync that is already
    // asserted when reset releases still produces exactly one edge.
    always_ff @(posedge clk) begin
        if (reset)
            prev <= ~SYNC_POL;
        else if (pix_en)
            prev <= sync;
    end

    assign assert_edge = pix_en && (sync == SYNC_POL) && (prev != SYNC_POL);

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, active-video and lock from an Hsynq/Vsynq pair.
// Define VGA_DEC_MEASURE_EN to add measured line/frame lengths and an error counter.
module vga_sync_decoder
    import vga_dec_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter bit SYNC_POL    = DEF_SYNC_POL,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        Hsynq,
    input  logic        Vsynq,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        active,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err
`ifdef VGA_DEC_MEASURE_EN
    ,
    output logic [15:0] h_total_meas,
    output logic [15:0] v_total_meas,
    output logic [7:0]  err_count
`endif
);

    localparam logic [16:0] H_TOTAL     = 17'(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam logic [16:0] V_TOTAL     = 17'(V_SYNC + V_BP + V_ACTIVE + V_FP);
    localparam logic [15:0] H_ACT_START = 16'(H_SYNC + H_BP);
    localparam logic [15:0] H_ACT_END   = 16'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [15:0] V_ACT_START = 16'(V_SYNC + V_BP);
    localparam logic [15:0] V_ACT_END   = 16'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [3:0]  LOCK_N      = 4'(LOCK_FRAMES);

    dec_state_t  state, state_nxt;
    logic [15:0] h_cnt, v_cnt, h_cnt_nxt, v_cnt_nxt;
    logic [3:0]  good_cnt, good_cnt_nxt;
    logic        h_seen, h_seen_nxt;
    logic        h_edge, v_edge;
    logic        line_bad, frame_bad, err_nxt, locked_nxt, in_active;

    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_h_edge (
        .clk(clk), .reset(reset), .pix_en(pix_en), .sync(Hsynq), .assert_edge(h_edge)
    );

    vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_v_edge (
        .clk(clk), .reset(reset), .pix_en(pix_en), .sync(Vsynq), .assert_edge(v_edge)
    );

    // The first line after reset is partial, so h_seen gates the line check.
    assign line_bad  = h_edge && h_seen && (({1'b0, h_cnt} + 17'd1) != H_TOTAL);
    assign frame_bad = v_edge && (({1'b0, v_cnt} + 17'd1) != V_TOTAL);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        h_cnt_nxt    = h_cnt;
        v_cnt_nxt    = v_cnt;
        h_seen_nxt   = h_seen;
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        err_nxt      = 1'b0;
        if (pix_en) begin
            h_cnt_nxt = h_edge ? 16'd0 : sat_inc16(h_cnt);
            if (v_edge)
                v_cnt_nxt = 16'd0;
            else if (h_edge)
                v_cnt_nxt = sat_inc16(v_cnt);
            if (h_edge)
                h_seen_nxt = 1'b1;
            case (state)
                SEARCH: begin
                    if (v_edge) begin
                        state_nxt    = CHECK;
                        good_cnt_nxt = 4'd0;
                    end
                end
                CHECK: begin
                    if (line_bad || frame_bad) begin
                        state_nxt = SEARCH;
                        err_nxt   = 1'b1;
                    end else if (v_edge) begin
                        good_cnt_nxt = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == LOCK_N)
                            state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (line_bad || frame_bad || (!h_edge && h_cnt == 16'hFFFF)) begin
                        state_nxt = SEARCH;
                        err_nxt   = 1'b1;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    assign locked_nxt = (state_nxt == LOCKED);
    assign in_active  = locked_nxt
                     && (h_cnt_nxt >= H_ACT_START) && (h_cnt_nxt <= H_ACT_END)
                     && (v_cnt_nxt >= V_ACT_START) && (v_cnt_nxt <= V_ACT_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            h_cnt       <= 16'd0;
            v_cnt       <= 16'd0;
            good_cnt    <= 4'd0;
            h_seen      <= 1'b0;
            x           <= 16'd0;
            y           <= 16'd0;
            active      <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            h_cnt       <= h_cnt_nxt;
            v_cnt       <= v_cnt_nxt;
            good_cnt    <= good_cnt_nxt;
            h_seen      <= h_seen_nxt;
            frame_start <= v_edge;
            sync_err    <= err_nxt;
            if (pix_en) begin
                locked <= locked_nxt;
                active <= in_active;
                x      <= in_active ? h_cnt_nxt - H_ACT_START : 16'd0;
                y      <= in_active ? v_cnt_nxt - V_ACT_START : 16'd0;
            end
        end
    end

`ifdef VGA_DEC_MEASURE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            h_total_meas <= 16'd0;
            v_total_meas <= 16'd0;
            err_count    <= 8'd0;
        end else begin
            if (h_edge)
                h_total_meas <= h_cnt + 16'd1;
            if (v_edge)
                v_total_meas <= v_cnt + 16'd1;
            if (err_nxt && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
